// File: rtl/text_overlay_renderer.sv
// Text/sprite overlay: composites up to N_SLOTS 8x16 font glyphs over the incoming VGA pixel.
// Three-stage pipeline: S0 hit test + font address, S1 font ROM wait, S2 bit select + output mux.
module text_overlay_renderer #(
  parameter int N_SLOTS      = 16,
  parameter int SLOT_W       = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [7:0]        In_R,
  input  logic [7:0]        In_G,
  input  logic [7:0]        In_B,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_slot,
  input  logic [6:0]        wr_char,
  input  logic [9:0]        wr_x,
  input  logic [9:0]        wr_y,
  input  logic [23:0]       wr_rgb,
  input  logic [2:0]        wr_attr,
  output logic [10:0]       font_addr,
  input  logic [7:0]        font_data,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue,
  output logic              out_valid
);

  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(2 * BLINK_FRAMES) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(2 * BLINK_FRAMES - 1);
  localparam logic [BC_W-1:0] BC_HALF = BC_W'(BLINK_FRAMES);

  // attr = {scale2, blink, enable}
  typedef struct packed {
    logic [6:0]  chr;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
    logic [2:0]  attr;
  } slot_t;

  slot_t           shadow_q [N_SLOTS];
  slot_t           shadow_d [N_SLOTS];
  slot_t           active_q [N_SLOTS];
  logic [BC_W-1:0] blink_cnt_q;
  logic [BC_W-1:0] blink_cnt_d;
  logic            blink_on;

  logic            hit_s0;
  logic [6:0]      sel_chr_s0;
  logic [3:0]      sel_x_s0;
  logic [4:0]      sel_y_s0;
  logic [23:0]     sel_rgb_s0;
  logic            sel_scale_s0;
  logic [3:0]      dx_s0;
  logic [4:0]      dy_s0;
  logic [3:0]      row_s0;
  logic [2:0]      col_s0;
  logic [10:0]     font_addr_d;

  logic            vld_p1;
  logic            hit_p1;
  logic [23:0]     rgb_p1;
  logic [23:0]     in_p1;
  logic [2:0]      col_p1;

  logic            vld_p2;
  logic            hit_p2;
  logic [23:0]     rgb_p2;
  logic [23:0]     in_p2;
  logic [2:0]      col_p2;

  logic            pix_bit_p2;
  logic [23:0]     out_rgb_d;

  // Extended to 11 bits so a glyph hanging past column/row 1023 never wraps to the left/top edge.
  function automatic logic slot_hit(input logic [9:0] sx, input logic [9:0] sy,
                                    input logic [2:0] attr, input logic [9:0] px,
                                    input logic [9:0] py, input logic vis_phase);
    logic [10:0] w;
    logic [10:0] h;
    w = attr[2] ? 11'd16 : 11'd8;
    h = attr[2] ? 11'd32 : 11'd16;
    return attr[0] && (!attr[1] || vis_phase) &&
           ({1'b0, px} >= {1'b0, sx}) && ({1'b0, px} < ({1'b0, sx} + w)) &&
           ({1'b0, py} >= {1'b0, sy}) && ({1'b0, py} < ({1'b0, sy} + h));
  endfunction

  // A write landing on the frame_start cycle must be part of that frame's commit.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_en && (32'(wr_slot) < N_SLOTS)) begin
      shadow_d[wr_slot].chr  = wr_char;
      shadow_d[wr_slot].x    = wr_x;
      shadow_d[wr_slot].y    = wr_y;
      shadow_d[wr_slot].rgb  = wr_rgb;
      shadow_d[wr_slot].attr = wr_attr;
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    if (frame_start) begin
      blink_cnt_d = (blink_cnt_q == BC_LAST) ? '0 : blink_cnt_q + 1'b1;
    end
  end

  assign blink_on = (blink_cnt_q < BC_HALF);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      blink_cnt_q <= '0;
    end else begin
      shadow_q    <= shadow_d;
      blink_cnt_q <= blink_cnt_d;
      if (frame_start) begin
        active_q <= shadow_d;
      end
    end
  end

  // ---- S0: hit test, priority select, font address ----
  always_comb begin
    hit_s0       = 1'b0;
    sel_chr_s0   = '0;
    sel_x_s0     = '0;
    sel_y_s0     = '0;
    sel_rgb_s0   = '0;
    sel_scale_s0 = 1'b0;
    // Scanning from the top index down lets the lowest hitting slot overwrite the rest.
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (pix_valid && slot_hit(active_q[i].x, active_q[i].y, active_q[i].attr,
                                DrawX, DrawY, blink_on)) begin
        hit_s0       = 1'b1;
        sel_chr_s0   = active_q[i].chr;
        sel_x_s0     = active_q[i].x[3:0];
        sel_y_s0     = active_q[i].y[4:0];
        sel_rgb_s0   = active_q[i].rgb;
        sel_scale_s0 = active_q[i].attr[2];
      end
    end
    // Offsets inside a hit are < 16 / < 32, so the low bits of the difference are exact.
    dx_s0       = DrawX[3:0] - sel_x_s0;
    dy_s0       = DrawY[4:0] - sel_y_s0;
    row_s0      = sel_scale_s0 ? dy_s0[4:1] : dy_s0[3:0];
    col_s0      = sel_scale_s0 ? dx_s0[3:1] : dx_s0[2:0];
    font_addr_d = hit_s0 ? {sel_chr_s0, row_s0} : '0;
  end

  // ---- S0 -> S1 ----
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_p1    <= 1'b0;
      hit_p1    <= 1'b0;
      font_addr <= '0;
    end else begin
      vld_p1    <= pix_valid;
      hit_p1    <= hit_s0;
      font_addr <= font_addr_d;
    end
  end

  always_ff @(posedge Clk) begin
    rgb_p1 <= sel_rgb_s0;
    in_p1  <= {In_R, In_G, In_B};
    col_p1 <= col_s0;
  end

  // ---- S1 -> S2: font ROM read in flight ----
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_p2 <= 1'b0;
      hit_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      hit_p2 <= hit_p1;
    end
  end

  always_ff @(posedge Clk) begin
    rgb_p2 <= rgb_p1;
    in_p2  <= in_p1;
    col_p2 <= col_p1;
  end

  // ---- S2: glyph bit select and output mux ----
  always_comb begin
    pix_bit_p2 = font_data[3'd7 - col_p2];
    out_rgb_d  = '0;
    if (vld_p2) begin
      out_rgb_d = (hit_p2 && pix_bit_p2) ? rgb_p2 : in_p2;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Red       <= '0;
      Green     <= '0;
      Blue      <= '0;
      out_valid <= 1'b0;
    end else begin
      Red       <= out_rgb_d[23:16];
      Green     <= out_rgb_d[15:8];
      Blue      <= out_rgb_d[7:0];
      out_valid <= vld_p2;
    end
  end

endmodule
